id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX operand stage of RVS192; sits directly downstream of the register file.
//  Takes decoded fields plus register file read data (rs1_out/rs2_out, valid before the posedge).
//  Resolves EX/MEM forwarding and load-use hazards, then registers the operands for EX.
//  Uses a valid/ready handshake: stalls decode on a load-use hazard or EX backpressure; kills on flush.
// PARAMETERS
//  DATA_LENGTH  32  operand/data width
//  REG_ADDR_W   5   register index width
// PORTS
//  clk          in   1            clock; all state updates on posedge
//  rst_n        in   1            reset; asynchronous, active-low
//  id_valid     in   1            decode presents an instruction
//  id_ready     out  1            stage accepts the instruction this cycle
//  id_rs1       in   REG_ADDR_W   source register 1 index
//  id_rs2       in   REG_ADDR_W   source register 2 index
//  id_rs1_used  in   1            instruction reads rs1
//  id_rs2_used  in   1            instruction reads rs2
//  id_rd        in   REG_ADDR_W   destination index
//  id_reg_wen   in   1            instruction writes rd
//  id_is_load   in   1            instruction is a load
//  id_pc        in   DATA_LENGTH  instruction PC
//  id_imm       in   DATA_LENGTH  decoded immediate
//  rf_rs1_data  in   DATA_LENGTH  register file read data for rs1
//  rf_rs2_data  in   DATA_LENGTH  register file read data for rs2
//  exe_data     in   DATA_LENGTH  EX result of instruction currently held in ex_* outputs
//  mem_rd       in   REG_ADDR_W   MEM stage destination index
//  mem_reg_wen  in   1            MEM stage writes rd, valid instr
//  mem_data     in   DATA_LENGTH  MEM stage final result, includes load data
//  flush        in   1            kill the instruction in ID and in the stage register
//  ex_ready     in   1            EX accepts the stage output
//  ex_valid     out  1            stage register holds a valid instruction
//  ex_op1       out  DATA_LENGTH  resolved rs1 operand
//  ex_op2       out  DATA_LENGTH  resolved rs2 operand
//  ex_rd        out  REG_ADDR_W   registered id_rd
//  ex_reg_wen   out  1            registered id_reg_wen
//  ex_is_load   out  1            registered id_is_load
//  ex_pc        out  DATA_LENGTH  registered id_pc
//  ex_imm       out  DATA_LENGTH  registered id_imm
//  hazard_stall out  1            load-use stall active this cycle
// BEHAVIOUR
//  Reset (rst_n=0, async): all ex_* outputs are 0, including ex_valid.
//   - id_ready=0 and hazard_stall=0 while in reset.
//  Operand select, per source s, combinational, in priority order:
//   1. rs==0 -> 0; x0 is never forwarded.
//   2. ex_valid && ex_reg_wen && !ex_is_load && ex_rd==rs -> exe_data.
//   3. mem_reg_wen && mem_rd==rs -> mem_data.
//   4. Otherwise rf_rs*_data. WB writes are already visible through the register file.
//  load_use = ex_valid && ex_is_load && ex_reg_wen && ex_rd!=0 &&
//   ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
//  hazard_stall = id_valid && load_use && !flush.
//  advance = !ex_valid || ex_ready.
//  id_ready = advance && !load_use && !flush.
//  Posedge update, in priority order:
//   1. flush: ex_valid<=0; the ID instruction is dropped, not transferred.
//   2. id_valid && id_ready: capture all fields and resolved operands; ex_valid<=1.
//   3. advance && !transfer: bubble; ex_valid<=0, other ex_* hold their values.
//   4. Otherwise (EX backpressure): all ex_* hold.
//  Latency: 1 cycle from accepted ID to ex_valid.
//  A load-use stall lasts exactly 1 cycle when ex_ready=1:
//   - the load moves to MEM;
//   - the dependent instruction then takes mem_data.
//  Operands are resolved only in the capture cycle; held outputs are never re-resolved.
//  Simultaneous flush and load_use: flush wins; hazard_stall=0.
//  Reset asserted mid-transfer: output clears immediately; no partial capture.
// TESTING
//  1. Reset: rst_n=0 while id_valid=1 -> ex_valid=0, ex_op1=0, id_ready=0.
//  2. RF path: rs1=3, rs2=4, rf=0x11/0x22, no matches
//     -> next cycle ex_op1=0x11, ex_op2=0x22, ex_valid=1.
//  3. Forward priority: ex_rd=5 (ALU), exe_data=0xAA, mem_rd=5, mem_data=0xBB, id_rs1=5
//     -> ex_op1=0xAA. Repeat with ex_reg_wen=0 -> ex_op1=0xBB.
//  4. x0: id_rs1=0, mem_rd=0, mem_reg_wen=1, mem_data=0xFF -> ex_op1=0.
//  5. Load-use: lw x7 in ex_*, next id uses x7 -> hazard_stall=1, id_ready=0, bubble;
//     next cycle mem_rd=7, mem_data=0x1234 -> ex_op1=0x1234.
//  6. Backpressure and flush: ex_ready=0 for 3 cycles -> ex_* stable, id_ready=0;
//     then flush=1 -> ex_valid=0 and the ID instruction is not captured.

Source files
------------

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of decode, register-file, forwarding and EX-side signals for the
// ID/EX operand stage. The master side is the surrounding pipeline (decode,
// register file, EX, MEM); the slave side is the operand stage itself.
interface id_ex_operand_stage_if #(
    parameter int DATA_LENGTH = 32,
    parameter int REG_ADDR_W  = 5
);
    // decode side
    logic                   id_valid;
    logic                   id_ready;
    logic [REG_ADDR_W-1:0]  id_rs1;
    logic [REG_ADDR_W-1:0]  id_rs2;
    logic                   id_rs1_used;
    logic                   id_rs2_used;
    logic [REG_ADDR_W-1:0]  id_rd;
    logic                   id_reg_wen;
    logic                   id_is_load;
    logic [DATA_LENGTH-1:0] id_pc;
    logic [DATA_LENGTH-1:0] id_imm;
    // register file read data
    logic [DATA_LENGTH-1:0] rf_rs1_data;
    logic [DATA_LENGTH-1:0] rf_rs2_data;
    // forwarding sources
    logic [DATA_LENGTH-1:0] exe_data;
    logic [REG_ADDR_W-1:0]  mem_rd;
    logic                   mem_reg_wen;
    logic [DATA_LENGTH-1:0] mem_data;
    // pipeline control
    logic                   flush;
    logic                   ex_ready;
    // stage register towards EX
    logic                   ex_valid;
    logic [DATA_LENGTH-1:0] ex_op1;
    logic [DATA_LENGTH-1:0] ex_op2;
    logic [REG_ADDR_W-1:0]  ex_rd;
    logic                   ex_reg_wen;
    logic                   ex_is_load;
    logic [DATA_LENGTH-1:0] ex_pc;
    logic [DATA_LENGTH-1:0] ex_imm;
    logic                   hazard_stall;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_wen, id_is_load, id_pc, id_imm, rf_rs1_data, rf_rs2_data,
               exe_data, mem_rd, mem_reg_wen, mem_data, flush, ex_ready,
        input  id_ready, ex_valid, ex_op1, ex_op2, ex_rd, ex_reg_wen,
               ex_is_load, ex_pc, ex_imm, hazard_stall
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_wen, id_is_load, id_pc, id_imm, rf_rs1_data, rf_rs2_data,
               exe_data, mem_rd, mem_reg_wen, mem_data, flush, ex_ready,
        output id_ready, ex_valid, ex_op1, ex_op2, ex_rd, ex_reg_wen,
               ex_is_load, ex_pc, ex_imm, hazard_stall
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage of RVS192. Resolves rs1/rs2 operands with EX/MEM
// forwarding, detects load-use hazards, and registers the instruction for EX
// behind a valid/ready handshake. Operands are resolved once, in the cycle the
// instruction is captured; held outputs are never re-resolved.
module id_ex_operand_stage #(
    parameter int DATA_LENGTH = 32,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    id_ex_operand_stage_if.slave  bus
);

    localparam logic [DATA_LENGTH-1:0] ZERO_DATA = {DATA_LENGTH{1'b0}};
    localparam logic [REG_ADDR_W-1:0]  ZERO_REG  = {REG_ADDR_W{1'b0}};

    // Operand priority: x0, then the ALU result in EX, then MEM, then the RF.
    // A load sitting in EX has no data yet, so ex_fwd_ok excludes it.
    function automatic logic [DATA_LENGTH-1:0] select_operand(
        input logic [REG_ADDR_W-1:0]  rs,
        input logic [DATA_LENGTH-1:0] rf_data,
        input logic                   ex_fwd_ok,
        input logic [REG_ADDR_W-1:0]  ex_rd,
        input logic [DATA_LENGTH-1:0] exe_data,
        input logic                   mem_wen,
        input logic [REG_ADDR_W-1:0]  mem_rd,
        input logic [DATA_LENGTH-1:0] mem_data
    );
        logic [DATA_LENGTH-1:0] op;
        if (rs == ZERO_REG) begin
            op = ZERO_DATA;
        end else if (ex_fwd_ok && (ex_rd == rs)) begin
            op = exe_data;
        end else if (mem_wen && (mem_rd == rs)) begin
            op = mem_data;
        end else begin
            op = rf_data;
        end
        return op;
    endfunction

    // stage register and its next state
    logic                   ex_valid_q,   ex_valid_d;
    logic [DATA_LENGTH-1:0] ex_op1_q,     ex_op1_d;
    logic [DATA_LENGTH-1:0] ex_op2_q,     ex_op2_d;
    logic [REG_ADDR_W-1:0]  ex_rd_q,      ex_rd_d;
    logic                   ex_reg_wen_q, ex_reg_wen_d;
    logic                   ex_is_load_q, ex_is_load_d;
    logic [DATA_LENGTH-1:0] ex_pc_q,      ex_pc_d;
    logic [DATA_LENGTH-1:0] ex_imm_q,     ex_imm_d;

    // combinational control
    logic                   ex_fwd_ok_s;
    logic                   load_use_s;
    logic                   advance_s;
    logic                   id_ready_s;
    logic                   hazard_stall_s;
    logic                   transfer_s;
    logic [DATA_LENGTH-1:0] op1_s;
    logic [DATA_LENGTH-1:0] op2_s;

    // Hazard detection and handshake; reset holds id_ready low.
    always_comb begin
        ex_fwd_ok_s = ex_valid_q && ex_reg_wen_q && !ex_is_load_q;
        load_use_s  = ex_valid_q && ex_is_load_q && ex_reg_wen_q &&
                      (ex_rd_q != ZERO_REG) &&
                      ((bus.id_rs1_used && (bus.id_rs1 == ex_rd_q)) ||
                       (bus.id_rs2_used && (bus.id_rs2 == ex_rd_q)));
        advance_s   = !ex_valid_q || bus.ex_ready;
        if (rst_n) begin
            id_ready_s     = advance_s && !load_use_s && !bus.flush;
            hazard_stall_s = bus.id_valid && load_use_s && !bus.flush;
        end else begin
            id_ready_s     = 1'b0;
            hazard_stall_s = 1'b0;
        end
        transfer_s = bus.id_valid && id_ready_s;
    end

    // Resolve both source operands from the forwarding network.
    always_comb begin
        op1_s = select_operand(bus.id_rs1, bus.rf_rs1_data, ex_fwd_ok_s, ex_rd_q,
                               bus.exe_data, bus.mem_reg_wen, bus.mem_rd, bus.mem_data);
        op2_s = select_operand(bus.id_rs2, bus.rf_rs2_data, ex_fwd_ok_s, ex_rd_q,
                               bus.exe_data, bus.mem_reg_wen, bus.mem_rd, bus.mem_data);
    end

    // Next state: flush kills, transfer captures, advance bubbles, else hold.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_op1_d     = ex_op1_q;
        ex_op2_d     = ex_op2_q;
        ex_rd_d      = ex_rd_q;
        ex_reg_wen_d = ex_reg_wen_q;
        ex_is_load_d = ex_is_load_q;
        ex_pc_d      = ex_pc_q;
        ex_imm_d     = ex_imm_q;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
        end else if (transfer_s) begin
            ex_valid_d   = 1'b1;
            ex_op1_d     = op1_s;
            ex_op2_d     = op2_s;
            ex_rd_d      = bus.id_rd;
            ex_reg_wen_d = bus.id_reg_wen;
            ex_is_load_d = bus.id_is_load;
            ex_pc_d      = bus.id_pc;
            ex_imm_d     = bus.id_imm;
        end else if (advance_s) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_op1_q     <= ZERO_DATA;
            ex_op2_q     <= ZERO_DATA;
            ex_rd_q      <= ZERO_REG;
            ex_reg_wen_q <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_pc_q      <= ZERO_DATA;
            ex_imm_q     <= ZERO_DATA;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_op1_q     <= ex_op1_d;
            ex_op2_q     <= ex_op2_d;
            ex_rd_q      <= ex_rd_d;
            ex_reg_wen_q <= ex_reg_wen_d;
            ex_is_load_q <= ex_is_load_d;
            ex_pc_q      <= ex_pc_d;
            ex_imm_q     <= ex_imm_d;
        end
    end

    assign bus.id_ready     = id_ready_s;
    assign bus.hazard_stall = hazard_stall_s;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_op1       = ex_op1_q;
    assign bus.ex_op2       = ex_op2_q;
    assign bus.ex_rd        = ex_rd_q;
    assign bus.ex_reg_wen   = ex_reg_wen_q;
    assign bus.ex_is_load   = ex_is_load_q;
    assign bus.ex_pc        = ex_pc_q;
    assign bus.ex_imm       = ex_imm_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: expected EX-side records are
// queued when an instruction is presented and expected to be accepted, and
// popped when EX takes the stage output (ex_valid && ex_ready before an edge).
module tb_id_ex_operand_stage;

    logic clk;
    logic rst_n;

    id_ex_operand_stage_if #(.DATA_LENGTH(32), .REG_ADDR_W(5)) bus ();

    id_ex_operand_stage #(.DATA_LENGTH(32), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        wen;
        logic        load;
        logic [31:0] pc;
        logic [31:0] imm;
    } exp_t;

    exp_t sb_q[$];
    exp_t nx;
    int   n_vec = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when it differs.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // EX takes the stage output: pop the oldest expected record and compare.
    task automatic consume();
        exp_t e;
        check_val("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_val("ex_op1",     bus.ex_op1,     e.op1);
            check_val("ex_op2",     bus.ex_op2,     e.op2);
            check_val("ex_rd",      bus.ex_rd,      e.rd);
            check_val("ex_reg_wen", bus.ex_reg_wen, e.wen);
            check_val("ex_is_load", bus.ex_is_load, e.load);
            check_val("ex_pc",      bus.ex_pc,      e.pc);
            check_val("ex_imm",     bus.ex_imm,     e.imm);
        end
    endtask

    task automatic present(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic wen, input logic load,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] rf1, input logic [31:0] rf2,
                           input logic [31:0] e1, input logic [31:0] e2);
        bus.id_valid    = 1'b1;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rs1_used = 1'b1;
        bus.id_rs2_used = 1'b1;
        bus.id_rd       = rd;
        bus.id_reg_wen  = wen;
        bus.id_is_load  = load;
        bus.id_pc       = pc;
        bus.id_imm      = imm;
        bus.rf_rs1_data = rf1;
        bus.rf_rs2_data = rf2;
        nx.op1 = e1;  nx.op2 = e2;  nx.rd = rd;  nx.wen = wen;
        nx.load = load;  nx.pc = pc;  nx.imm = imm;
    endtask

    task automatic idle();
        bus.id_valid    = 1'b0;
        bus.id_rs1_used = 1'b0;
        bus.id_rs2_used = 1'b0;
        bus.id_rs1      = 5'd0;
        bus.id_rs2      = 5'd0;
    endtask

    // One cycle: check handshake outputs, score EX consumption, queue accepted ID.
    task automatic step(input logic exp_rdy, input logic exp_stall);
        #1;
        check_val("id_ready",     bus.id_ready,     exp_rdy);
        check_val("hazard_stall", bus.hazard_stall, exp_stall);
        if (bus.ex_valid && bus.ex_ready) consume();
        if (bus.id_valid && exp_rdy) sb_q.push_back(nx);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        bus.id_rd = 5'd0; bus.id_reg_wen = 1'b0; bus.id_is_load = 1'b0;
        bus.id_pc = 32'd0; bus.id_imm = 32'd0;
        bus.rf_rs1_data = 32'd0; bus.rf_rs2_data = 32'd0;
        bus.exe_data = 32'd0; bus.mem_rd = 5'd0; bus.mem_reg_wen = 1'b0;
        bus.mem_data = 32'd0; bus.flush = 1'b0; bus.ex_ready = 1'b1;

        // reset with an instruction presented
        present(5'd3, 5'd4, 5'd1, 1'b1, 1'b0, 32'h10, 32'h1, 32'h11, 32'h22, 32'h11, 32'h22);
        #2;
        check_val("rst_ex_valid",  bus.ex_valid,     1'b0);
        check_val("rst_ex_op1",    bus.ex_op1,       32'd0);
        check_val("rst_id_ready",  bus.id_ready,     1'b0);
        check_val("rst_stall",     bus.hazard_stall, 1'b0);
        @(posedge clk); #1;
        check_val("rst_ex_valid2", bus.ex_valid,     1'b0);
        check_val("rst_ex_pc",     bus.ex_pc,        32'd0);
        rst_n = 1'b1;
        idle();

        // RF path, one-cycle latency
        present(5'd3, 5'd4, 5'd1, 1'b1, 1'b0, 32'h100, 32'h8, 32'h11, 32'h22, 32'h11, 32'h22);
        step(1'b1, 1'b0);
        check_val("rf_latency_valid", bus.ex_valid, 1'b1);
        idle();
        step(1'b1, 1'b0);

        // EX beats MEM when both match
        present(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0);
        bus.exe_data = 32'hAA; bus.mem_rd = 5'd5; bus.mem_reg_wen = 1'b1; bus.mem_data = 32'hBB;
        present(5'd5, 5'd6, 5'd9, 1'b1, 1'b0, 32'h204, 32'h4, 32'h55, 32'h66, 32'hAA, 32'h66);
        step(1'b1, 1'b0);
        // EX producer without reg write: MEM forwards
        bus.mem_reg_wen = 1'b0;
        present(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 32'h208, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0);
        bus.mem_rd = 5'd5; bus.mem_reg_wen = 1'b1; bus.mem_data = 32'hBB;
        present(5'd5, 5'd6, 5'd13, 1'b1, 1'b0, 32'h20C, 32'h0, 32'h55, 32'h66, 32'hBB, 32'h66);
        step(1'b1, 1'b0);

        // x0 is never forwarded
        bus.mem_rd = 5'd0; bus.mem_data = 32'hFF;
        present(5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 32'h300, 32'h0, 32'h77, 32'h77, 32'h0, 32'h0);
        step(1'b1, 1'b0);
        // MEM on rs1 only
        bus.mem_rd = 5'd3; bus.mem_data = 32'hCC;
        present(5'd3, 5'd4, 5'd15, 1'b1, 1'b0, 32'h304, 32'h0, 32'h11, 32'h22, 32'hCC, 32'h22);
        step(1'b1, 1'b0);
        // EX on rs2 only
        bus.mem_reg_wen = 1'b0;
        present(5'd6, 5'd15, 5'd16, 1'b1, 1'b0, 32'h308, 32'h0, 32'h66, 32'h99, 32'h66, 32'hAA);
        step(1'b1, 1'b0);
        idle();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // load-use: one stall cycle, then the load result arrives from MEM
        present(5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 32'h400, 32'h10, 32'h1000, 32'h0, 32'h1000, 32'h0);
        step(1'b1, 1'b0);
        present(5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 32'h404, 32'h0, 32'hDEAD, 32'h0, 32'h1234, 32'h0);
        step(1'b0, 1'b1);
        check_val("lu_bubble", bus.ex_valid, 1'b0);
        bus.mem_rd = 5'd7; bus.mem_reg_wen = 1'b1; bus.mem_data = 32'h1234;
        step(1'b1, 1'b0);
        check_val("lu_capture", bus.ex_valid, 1'b1);
        bus.mem_reg_wen = 1'b0;
        idle();
        step(1'b1, 1'b0);

        // EX backpressure for three cycles, then flush
        present(5'd3, 5'd0, 5'd10, 1'b1, 1'b0, 32'h600, 32'h0, 32'h33, 32'h0, 32'h33, 32'h0);
        step(1'b1, 1'b0);
        bus.ex_ready = 1'b0;
        present(5'd4, 5'd0, 5'd11, 1'b1, 1'b0, 32'h604, 32'h0, 32'h44, 32'h0, 32'h44, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check_val("bp_valid", bus.ex_valid, 1'b1);
            check_val("bp_op1",   bus.ex_op1,   32'h33);
            check_val("bp_pc",    bus.ex_pc,    32'h600);
        end
        bus.flush = 1'b1;
        step(1'b0, 1'b0);
        check_val("flush_valid", bus.ex_valid, 1'b0);
        check_val("flush_sb", sb_q.size(), 64'd1);
        sb_q.delete();
        bus.flush = 1'b0; bus.ex_ready = 1'b1;
        idle();
        step(1'b1, 1'b0);
        check_val("flush_nocap", bus.ex_valid, 1'b0);

        // flush coincident with load-use: flush wins, no stall reported
        present(5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 32'h700, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0);
        present(5'd12, 5'd0, 5'd18, 1'b1, 1'b0, 32'h704, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.flush = 1'b1;
        step(1'b0, 1'b0);
        check_val("flush_lu_valid", bus.ex_valid, 1'b0);
        bus.flush = 1'b0;
        idle();
        step(1'b1, 1'b0);

        // reset asserted with an instruction held and another being presented
        present(5'd3, 5'd4, 5'd17, 1'b1, 1'b0, 32'h800, 32'h5, 32'h11, 32'h22, 32'h11, 32'h22);
        step(1'b1, 1'b0);
        present(5'd4, 5'd3, 5'd19, 1'b1, 1'b0, 32'h804, 32'h6, 32'h22, 32'h11, 32'h22, 32'h11);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_valid", bus.ex_valid, 1'b0);
        check_val("rst_mid_op1",   bus.ex_op1,   32'd0);
        check_val("rst_mid_ready", bus.id_ready, 1'b0);
        @(posedge clk); #1;
        check_val("rst_mid_pc",    bus.ex_pc,    32'd0);
        check_val("rst_mid_sb", sb_q.size(), 64'd1);
        sb_q.delete();
        rst_n = 1'b1;
        idle();
        step(1'b1, 1'b0);
        check_val("post_rst_valid", bus.ex_valid, 1'b0);

        check_val("sb_drain", sb_q.size(), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
